dev_bridge: RTL and testbench

DEV_BRIDGE -- requirements
Module: dev_bridge

---
 rtl/dev_bridge_pkg.sv | 40 ++++
 rtl/dev_bridge_if.sv | 36 +++
 rtl/dev_bridge_irq.sv | 48 ++++
 rtl/dev_bridge.sv | 74 +++++++
 tb/tb_dev_bridge.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dev_bridge_pkg.sv
// Shared definitions for the timer/interrupt device bridge.
// Holds window offsets, device count, the select enumeration and the decoder.
// No state; pure types, constants and combinational helpers.
package dev_bridge_pkg;

    localparam int DEV_COUNT = 2;

    // Byte offsets from the window base
    localparam logic [31:0] OFF_TMR0  = 32'h0000_0000;
    localparam logic [31:0] OFF_TMR1  = 32'h0000_0010;
    localparam logic [31:0] OFF_PEND  = 32'h0000_0020;
    localparam logic [31:0] OFF_MASK  = 32'h0000_0024;
    localparam logic [31:0] OFF_CAUSE = 32'h0000_0028;

    // Each timer decodes three registers (12 bytes)
    localparam logic [31:0] TMR_SPAN  = 32'h0000_000C;

    typedef enum logic [2:0] {
        SEL_TMR0,
        SEL_TMR1,
        SEL_PEND,
        SEL_MASK,
        SEL_CAUSE,
        SEL_NONE
    } sel_t;

    // Offset is relative to the window base and already word aligned.
    // Unsigned subtraction makes offsets below a range wrap high and miss.
    function automatic sel_t decode(input logic [31:0] off);
        sel_t s;
        if ((off - OFF_TMR0) < TMR_SPAN)      s = SEL_TMR0;
        else if ((off - OFF_TMR1) < TMR_SPAN) s = SEL_TMR1;
        else if (off == OFF_PEND)             s = SEL_PEND;
        else if (off == OFF_MASK)             s = SEL_MASK;
        else if (off == OFF_CAUSE)            s = SEL_CAUSE;
        else                                  s = SEL_NONE;
        return s;
    endfunction

endpackage

// File: rtl/dev_bridge_if.sv
// CPU-side and device-side bus of the bridge bundled as one interface.
// The bridge uses the slave view; the CPU/testbench side uses the master view.
// No flow control beyond the one-cycle request/ack pairing.
interface dev_bridge_if;
    import dev_bridge_pkg::*;

    logic                 cpu_req_i;
    logic                 cpu_we_i;
    logic [31:0]          cpu_addr_i;
    logic [31:0]          cpu_wdata_i;
    logic                 cpu_ack_o;
    logic [31:0]          cpu_rdata_o;
    logic                 cpu_err_o;
    logic                 cpu_int_o;
    logic [DEV_COUNT-1:0] dev_we_o;
    logic [1:0]           dev_addr_o;
    logic [31:0]          dev_wdata_o;
    logic [31:0]          dev0_rdata_i;
    logic [31:0]          dev1_rdata_i;
    logic [DEV_COUNT-1:0] dev_irq_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  dev0_rdata_i, dev1_rdata_i, dev_irq_i,
        output cpu_ack_o, cpu_rdata_o, cpu_err_o, cpu_int_o,
        output dev_we_o, dev_addr_o, dev_wdata_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output dev0_rdata_i, dev1_rdata_i, dev_irq_i,
        input  cpu_ack_o, cpu_rdata_o, cpu_err_o, cpu_int_o,
        input  dev_we_o, dev_addr_o, dev_wdata_o
    );

endinterface

// File: rtl/dev_bridge_irq.sv
// Interrupt block: latches timer pulses into PENDING, holds MASK, encodes CAUSE.
// PENDING/MASK update on the clock edge; cause and int_req are combinational from them.
// Never stalls; a set pulse beats a write-1-clear of the same bit.
module dev_bridge_irq
    import dev_bridge_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DEV_COUNT-1:0] irq,
    input  logic                 pend_clr_en,
    input  logic                 mask_wr_en,
    input  logic [DEV_COUNT-1:0] wdata,
    output logic [DEV_COUNT-1:0] pending,
    output logic [DEV_COUNT-1:0] mask,
    output logic [31:0]          cause,
    output logic                 int_req
);

    logic [DEV_COUNT-1:0] active;
    logic [DEV_COUNT-1:0] clr;

    assign clr     = pend_clr_en ? wdata : '0;
    assign active  = pending & mask;
    assign int_req = |active;

    // Latch pulses (masked or not) and apply write-1-clear; set has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            mask    <= '0;
        end else begin
            pending <= (pending & ~clr) | irq;
            if (mask_wr_en) mask <= wdata;
        end
    end

    // Report the lowest-index unmasked pending source; bit31 flags any
    always_comb begin
        cause = '0;
        for (int i = DEV_COUNT - 1; i >= 0; i--) begin
            if (active[i]) begin
                cause[31]  = 1'b1;
                cause[1:0] = 2'(i);
            end
        end
    end

endmodule

// File: rtl/dev_bridge.sv
// CPU-to-timer bridge: address decode, device write strobes, registered read mux.
// Latency: response (ack/err/rdata) exactly one cycle after each request.
// No backpressure: a new request is accepted every cycle.
module dev_bridge
    import dev_bridge_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input logic        clk,
    input logic        rst_n,
    dev_bridge_if.slave bus
);

    logic [31:0]          off;
    sel_t                 sel;
    logic                 wr;
    logic [31:0]          rd_mux;
    logic [DEV_COUNT-1:0] pending;
    logic [DEV_COUNT-1:0] mask;
    logic [31:0]          cause;
    logic                 int_req;

    // Byte lanes are ignored; BASE is word aligned so masking first is exact
    assign off = (bus.cpu_addr_i & ~32'h3) - BASE;
    assign sel = decode(off);
    assign wr  = bus.cpu_req_i & bus.cpu_we_i;

    // Strobes are gated by reset so nothing reaches the timers while held
    assign bus.dev_we_o    = {rst_n & wr & (sel == SEL_TMR1),
                              rst_n & wr & (sel == SEL_TMR0)};
    assign bus.dev_addr_o  = bus.cpu_addr_i[3:2];
    assign bus.dev_wdata_o = bus.cpu_wdata_i;
    assign bus.cpu_int_o   = int_req;

    dev_bridge_irq u_irq (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq         (bus.dev_irq_i),
        .pend_clr_en (wr & (sel == SEL_PEND)),
        .mask_wr_en  (wr & (sel == SEL_MASK)),
        .wdata       (bus.cpu_wdata_i[DEV_COUNT-1:0]),
        .pending     (pending),
        .mask        (mask),
        .cause       (cause),
        .int_req     (int_req)
    );

    // Select the read source for the addressed register
    always_comb begin
        rd_mux = '0;
        case (sel)
            SEL_TMR0:  rd_mux = bus.dev0_rdata_i;
            SEL_TMR1:  rd_mux = bus.dev1_rdata_i;
            SEL_PEND:  rd_mux = {{(32-DEV_COUNT){1'b0}}, pending};
            SEL_MASK:  rd_mux = {{(32-DEV_COUNT){1'b0}}, mask};
            SEL_CAUSE: rd_mux = cause;
            default:   rd_mux = '0;
        endcase
    end

    // Register the response; reset drops any request in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cpu_ack_o   <= 1'b0;
            bus.cpu_err_o   <= 1'b0;
            bus.cpu_rdata_o <= '0;
        end else begin
            bus.cpu_ack_o   <= bus.cpu_req_i;
            bus.cpu_err_o   <= bus.cpu_req_i & (sel == SEL_NONE);
            bus.cpu_rdata_o <= (bus.cpu_req_i & ~bus.cpu_we_i) ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_dev_bridge.sv
// Self-checking bench for dev_bridge: directed vector table, reset sequences,
// and randomized traffic against a register-level reference model.
module tb_dev_bridge;

    localparam logic [31:0] B = 32'h0000_7F00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    dev_bridge_if bus();

    dev_bridge #(.BASE(B)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  irq;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  e_we;
        logic        e_ack;
        logic        e_err;
        logic [31:0] e_rdata;
        logic        e_int;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input logic req, input logic we, input logic [31:0] off,
                                 input logic [31:0] wdata, input logic [1:0] irq,
                                 input logic [1:0] e_we, input logic e_ack, input logic e_err,
                                 input logic [31:0] e_rdata, input logic e_int);
        vec_t v;
        v.req = req; v.we = we; v.addr = B + off; v.wdata = wdata; v.irq = irq;
        v.d0 = 32'hAAAA_5555; v.d1 = 32'h0000_1234;
        v.e_we = e_we; v.e_ack = e_ack; v.e_err = e_err; v.e_rdata = e_rdata; v.e_int = e_int;
        return v;
    endfunction

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] irq,
                         input logic [31:0] d0, input logic [31:0] d1);
        bus.cpu_req_i    = req;
        bus.cpu_we_i     = we;
        bus.cpu_addr_i   = addr;
        bus.cpu_wdata_i  = wdata;
        bus.dev_irq_i    = irq;
        bus.dev0_rdata_i = d0;
        bus.dev1_rdata_i = d1;
    endtask

    // Reference model state and helpers (register-level view)
    logic [1:0] m_pend;
    logic [1:0] m_mask;

    // 0=timer0 1=timer1 2=PENDING 3=MASK 4=CAUSE 5=unmapped, by word index
    function automatic int m_target(input logic [31:0] addr);
        logic [31:0] w, bw;
        w  = addr >> 2;
        bw = B >> 2;
        if (w >= bw && w < bw + 3)          return 0;
        if (w >= bw + 4 && w < bw + 7)      return 1;
        if (w == bw + 8)                    return 2;
        if (w == bw + 9)                    return 3;
        if (w == bw + 10)                   return 4;
        return 5;
    endfunction

    function automatic logic [31:0] m_cause(input logic [1:0] p, input logic [1:0] m);
        for (int n = 0; n < 2; n++)
            if (p[n] && m[n]) return 32'h8000_0000 | n;
        return 32'h0;
    endfunction

    vec_t tbl[24];

    initial begin
        logic [31:0] offs [13];
        logic [31:0] addr, wdata, d0, d1, e_rd;
        logic [1:0]  irq, e_we;
        logic        req, we;
        int          tgt, k;

        offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18,
                 32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30};

        //           req we  off          wdata         irq    we     ack  err  rdata          int
        tbl[0]  = mkv(1, 1, 32'h00,       32'h9,        2'b00, 2'b01, 1, 0, 32'h0,          0);
        tbl[1]  = mkv(1, 0, 32'h14,       32'h0,        2'b00, 2'b00, 1, 0, 32'h0000_1234,  0);
        tbl[2]  = mkv(1, 0, 32'h04,       32'h0,        2'b00, 2'b00, 1, 0, 32'hAAAA_5555,  0);
        tbl[3]  = mkv(1, 0, 32'h30,       32'h0,        2'b00, 2'b00, 1, 1, 32'h0,          0);
        tbl[4]  = mkv(0, 0, 32'h00,       32'h0,        2'b10, 2'b00, 0, 0, 32'h0,          0);
        tbl[5]  = mkv(1, 0, 32'h20,       32'h0,        2'b00, 2'b00, 1, 0, 32'h2,          0);
        tbl[6]  = mkv(1, 1, 32'h24,       32'hFFFF_FFFF,2'b00, 2'b00, 1, 0, 32'h0,          1);
        tbl[7]  = mkv(1, 0, 32'h24,       32'h0,        2'b00, 2'b00, 1, 0, 32'h3,          1);
        tbl[8]  = mkv(1, 0, 32'h28,       32'h0,        2'b00, 2'b00, 1, 0, 32'h8000_0001,  1);
        tbl[9]  = mkv(0, 0, 32'h00,       32'h0,        2'b01, 2'b00, 0, 0, 32'h0,          1);
        tbl[10] = mkv(1, 0, 32'h28,       32'h0,        2'b00, 2'b00, 1, 0, 32'h8000_0000,  1);
        tbl[11] = mkv(1, 1, 32'h20,       32'h1,        2'b00, 2'b00, 1, 0, 32'h0,          1);
        tbl[12] = mkv(1, 0, 32'h28,       32'h0,        2'b00, 2'b00, 1, 0, 32'h8000_0001,  1);
        tbl[13] = mkv(1, 1, 32'h20,       32'h2,        2'b10, 2'b00, 1, 0, 32'h0,          1);
        tbl[14] = mkv(1, 0, 32'h20,       32'h0,        2'b00, 2'b00, 1, 0, 32'h2,          1);
        tbl[15] = mkv(1, 1, 32'h28,       32'hFFFF,     2'b00, 2'b00, 1, 0, 32'h0,          1);
        tbl[16] = mkv(1, 1, 32'h20,       32'h3,        2'b00, 2'b00, 1, 0, 32'h0,          0);
        tbl[17] = mkv(1, 0, 32'h28,       32'h0,        2'b00, 2'b00, 1, 0, 32'h0,          0);
        tbl[18] = mkv(1, 1, 32'h0C,       32'h5,        2'b00, 2'b00, 1, 1, 32'h0,          0);
        tbl[19] = mkv(1, 1, 32'h18,       32'h7,        2'b00, 2'b10, 1, 0, 32'h0,          0);
        tbl[20] = mkv(1, 0, 32'h1B,       32'h0,        2'b00, 2'b00, 1, 0, 32'h0000_1234,  0);
        tbl[21] = mkv(1, 0, 32'h0B,       32'h0,        2'b00, 2'b00, 1, 0, 32'hAAAA_5555,  0);
        tbl[22] = mkv(1, 0, 32'hFFFF_FFFC,32'h0,        2'b00, 2'b00, 1, 1, 32'h0,          0);
        tbl[23] = mkv(0, 0, 32'h00,       32'h0,        2'b00, 2'b00, 0, 0, 32'h0,          0);

        // Reset state, with a timer write presented while reset is held
        drive(1, 1, B, 32'h5, 2'b11, 32'h1, 32'h2);
        #2;
        chk("rst_ack",   {31'b0, bus.cpu_ack_o}, 32'h0);
        chk("rst_err",   {31'b0, bus.cpu_err_o}, 32'h0);
        chk("rst_rdata", bus.cpu_rdata_o, 32'h0);
        chk("rst_int",   {31'b0, bus.cpu_int_o}, 32'h0);
        chk("rst_dev_we",{30'b0, bus.dev_we_o}, 32'h0);

        // Directed table; the first vector is applied on the release edge
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i > 0) @(negedge clk);
            drive(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].irq, tbl[i].d0, tbl[i].d1);
            #1;
            chk($sformatf("tbl%0d_dev_we", i),    {30'b0, bus.dev_we_o}, {30'b0, tbl[i].e_we});
            chk($sformatf("tbl%0d_dev_addr", i),  {30'b0, bus.dev_addr_o}, {30'b0, tbl[i].addr[3:2]});
            chk($sformatf("tbl%0d_dev_wdata", i), bus.dev_wdata_o, tbl[i].wdata);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_ack", i),   {31'b0, bus.cpu_ack_o}, {31'b0, tbl[i].e_ack});
            chk($sformatf("tbl%0d_err", i),   {31'b0, bus.cpu_err_o}, {31'b0, tbl[i].e_err});
            chk($sformatf("tbl%0d_rdata", i), bus.cpu_rdata_o, tbl[i].e_rdata);
            chk($sformatf("tbl%0d_int", i),   {31'b0, bus.cpu_int_o}, {31'b0, tbl[i].e_int});
        end

        // Reset mid-read with PENDING=3 and MASK=3
        @(negedge clk);
        drive(0, 0, B, 32'h0, 2'b11, 32'h1, 32'h0000_1234);
        @(negedge clk);
        drive(1, 1, B + 32'h24, 32'h3, 2'b00, 32'h1, 32'h0000_1234);
        @(posedge clk); #1;
        chk("pre_rst_int", {31'b0, bus.cpu_int_o}, 32'h1);
        chk("pre_rst_ack", {31'b0, bus.cpu_ack_o}, 32'h1);
        @(negedge clk);
        drive(1, 0, B + 32'h14, 32'h0, 2'b00, 32'h1, 32'h0000_1234);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ack",   {31'b0, bus.cpu_ack_o}, 32'h0);
        chk("midrst_err",   {31'b0, bus.cpu_err_o}, 32'h0);
        chk("midrst_rdata", bus.cpu_rdata_o, 32'h0);
        chk("midrst_int",   {31'b0, bus.cpu_int_o}, 32'h0);
        bus.cpu_we_i   = 1'b1;
        bus.cpu_addr_i = B;
        #1;
        chk("midrst_dev_we", {30'b0, bus.dev_we_o}, 32'h0);
        @(posedge clk); #1;
        chk("inrst_ack", {31'b0, bus.cpu_ack_o}, 32'h0);
        @(negedge clk);
        drive(0, 0, B, 32'h0, 2'b00, 32'h1, 32'h0000_1234);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_noack", {31'b0, bus.cpu_ack_o}, 32'h0);
        chk("postrst_int",   {31'b0, bus.cpu_int_o}, 32'h0);
        @(negedge clk);
        drive(1, 0, B + 32'h20, 32'h0, 2'b00, 32'h1, 32'h0000_1234);
        @(posedge clk); #1;
        chk("postrst_pend_ack",   {31'b0, bus.cpu_ack_o}, 32'h1);
        chk("postrst_pend_rdata", bus.cpu_rdata_o, 32'h0);

        // Request presented on the very first edge after release
        @(negedge clk);
        drive(0, 0, B, 32'h0, 2'b00, 32'h1, 32'h0000_1234);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, B + 32'h10, 32'h0, 2'b00, 32'h1, 32'h0000_1234);
        @(posedge clk); #1;
        chk("first_edge_ack",   {31'b0, bus.cpu_ack_o}, 32'h1);
        chk("first_edge_rdata", bus.cpu_rdata_o, 32'h0000_1234);

        // Randomized traffic against the reference model
        m_pend = 2'b00;
        m_mask = 2'b00;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req = 1'($urandom_range(0, 3) != 0);
            we  = 1'($urandom_range(0, 1));
            k   = $urandom_range(0, 13);
            addr  = (k == 13) ? $urandom : B + offs[k] + $urandom_range(0, 3);
            wdata = $urandom;
            irq   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            d0    = $urandom;
            d1    = $urandom;
            drive(req, we, addr, wdata, irq, d0, d1);

            tgt  = m_target(addr);
            e_we = 2'b00;
            if (req && we && tgt == 0) e_we[0] = 1'b1;
            if (req && we && tgt == 1) e_we[1] = 1'b1;
            e_rd = 32'h0;
            if (req && !we) begin
                case (tgt)
                    0: e_rd = d0;
                    1: e_rd = d1;
                    2: e_rd = {30'b0, m_pend};
                    3: e_rd = {30'b0, m_mask};
                    4: e_rd = m_cause(m_pend, m_mask);
                    default: e_rd = 32'h0;
                endcase
            end
            if (req && we && tgt == 2) m_pend = m_pend & ~wdata[1:0];
            m_pend = m_pend | irq;
            if (req && we && tgt == 3) m_mask = wdata[1:0];

            #1;
            chk($sformatf("rnd%0d_dev_we", c), {30'b0, bus.dev_we_o}, {30'b0, e_we});
            @(posedge clk); #1;
            chk($sformatf("rnd%0d_ack", c),   {31'b0, bus.cpu_ack_o}, {31'b0, req});
            chk($sformatf("rnd%0d_err", c),   {31'b0, bus.cpu_err_o}, {31'b0, req && tgt == 5});
            chk($sformatf("rnd%0d_rdata", c), bus.cpu_rdata_o, e_rd);
            chk($sformatf("rnd%0d_int", c),   {31'b0, bus.cpu_int_o}, {31'b0, |(m_pend & m_mask)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
